// File: rtl/ro_slot_scheduler.sv
// ro_slot_scheduler: ruler-sequence time-slot scheduler for the shared readout bus.
// Each slot is owned by one core, picked as ctz(cnt) (slot 0 goes to the top core).
// A core with pending data gets a one-cycle active-low tristate enable. The next
// cycle its event/polarity bits are registered onto the output port.
module ro_slot_scheduler #(
  parameter  int N_CH  = 8,
  localparam int CNT_W = N_CH - 1,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic              clk_master,
  input  logic              reset,
  input  logic              en,
  input  logic [N_CH-1:0]   ch_req,
  input  logic [N_CH-1:0]   ch_eve,
  input  logic [N_CH-1:0]   ch_pol,
  output logic [N_CH-1:0]   grant_b,
  output logic              out_eve,
  output logic              out_pol,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic              frame_start,
  output logic [CNT_W-1:0]  gray_out,
  output logic [N_CH-1:0]   overrun
);

  // Slot counter and per-core bookkeeping
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  pending_q, pending_d;
  logic [N_CH-1:0]  overrun_q, overrun_d;

  // Stage 1 (grant) registers
  logic [N_CH-1:0]  grant_b_q;
  logic [CH_W-1:0]  sel_q;
  logic             gvalid_q;
  logic             frame_q;
  logic [CNT_W-1:0] gray_q;

  // Stage 2 (output) registers
  logic             out_eve_q, out_pol_q, out_valid_q;
  logic [CH_W-1:0]  out_ch_q;

  // Decode outputs
  logic [CH_W-1:0]  sel;
  logic             grant_now;
  logic [N_CH-1:0]  grant_vec;

  // Slot owner: index of the lowest set bit of cnt, or the top core for cnt==0
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    sel = CH_W'(N_CH - 1);
    for (int k = N_CH - 2; k >= 0; k--) begin
      if (cnt_q[k]) sel = CH_W'(k);
    end
  end

  // Grant decision and next-state for counter, pending and overrun flags
  always_comb begin
    grant_now = en && pending_q[sel];
    grant_vec = grant_now ? (N_CH'(1) << sel) : '0;
    cnt_d     = en ? cnt_q + CNT_W'(1) : cnt_q;
    // A request coinciding with its own grant re-arms pending without an overrun
    pending_d = (pending_q & ~grant_vec) | ch_req;
    overrun_d = overrun_q | (ch_req & pending_q & ~grant_vec);
  end

  // Two-stage pipeline plus scheduler state, all synchronously reset
  always_ff @(posedge clk_master) begin
    if (reset) begin
      cnt_q       <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      grant_b_q   <= '1;
      sel_q       <= '0;
      gvalid_q    <= 1'b0;
      frame_q     <= 1'b0;
      gray_q      <= '0;
      out_eve_q   <= 1'b0;
      out_pol_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      grant_b_q <= ~grant_vec;
      sel_q     <= sel;
      gvalid_q  <= grant_now;
      frame_q   <= en && (cnt_q == '0);
      gray_q    <= cnt_q ^ (cnt_q >> 1);
      // Stage 2 is not gated by en so an in-flight grant always completes
      out_valid_q <= gvalid_q;
      if (gvalid_q) begin
        out_eve_q <= ch_eve[sel_q];
        out_pol_q <= ch_pol[sel_q];
        out_ch_q  <= sel_q;
      end
    end
  end

  assign grant_b     = grant_b_q;
  assign out_eve     = out_eve_q;
  assign out_pol     = out_pol_q;
  assign out_valid   = out_valid_q;
  assign out_ch      = out_ch_q;
  assign frame_start = frame_q;
  assign gray_out    = gray_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_ro_slot_scheduler.sv
// Testbench for ro_slot_scheduler: directed scenarios plus random traffic, every
// cycle compared against a slot-ownership reference model kept in the bench.
module tb_ro_slot_scheduler;

  localparam int N_CH  = 8;
  localparam int CNT_W = 7;
  localparam int CH_W  = 3;
  localparam int FRAME = 128;

  logic              clk_master = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic [N_CH-1:0]   ch_req = '0;
  logic [N_CH-1:0]   ch_eve = '0;
  logic [N_CH-1:0]   ch_pol = '0;
  logic [N_CH-1:0]   grant_b;
  logic              out_eve, out_pol, out_valid, frame_start;
  logic [CH_W-1:0]   out_ch;
  logic [CNT_W-1:0]  gray_out;
  logic [N_CH-1:0]   overrun;

  always #5 clk_master = ~clk_master;

  ro_slot_scheduler #(.N_CH(N_CH)) dut (
    .clk_master (clk_master),
    .reset      (reset),
    .en         (en),
    .ch_req     (ch_req),
    .ch_eve     (ch_eve),
    .ch_pol     (ch_pol),
    .grant_b    (grant_b),
    .out_eve    (out_eve),
    .out_pol    (out_pol),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .frame_start(frame_start),
    .gray_out   (gray_out),
    .overrun    (overrun)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (reset values)
  int        m_cnt   = 0;
  bit [7:0]  m_pend  = '0;
  bit [7:0]  m_ovr   = '0;
  int        m_gnt   = -1;
  bit        m_valid = 1'b0;
  int        m_och   = 0;
  bit        m_oeve  = 1'b0;
  bit        m_opol  = 1'b0;
  bit        m_frame = 1'b0;
  int        m_gray  = 0;

  int step_no = 0;
  int glog_step[$];
  int glog_ch[$];

  // Core k owns slots where cnt mod 2^(k+1) == 2^k; slot 0 belongs to the top core
  function automatic int slot_owner(input int c);
    if (c == 0) return N_CH - 1;
    for (int k = 0; k < N_CH - 1; k++) begin
      if ((c % (1 << (k + 1))) == (1 << k)) return k;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs currently applied
  task automatic model_edge();
    int       owner;
    int       prev;
    bit [7:0] served;
    if (reset) begin
      m_cnt = 0; m_pend = '0; m_ovr = '0; m_gnt = -1; m_valid = 1'b0;
      m_och = 0; m_oeve = 1'b0; m_opol = 1'b0; m_frame = 1'b0; m_gray = 0;
    end else begin
      owner  = slot_owner(m_cnt);
      prev   = m_gnt;
      served = '0;
      if (prev >= 0) begin
        m_valid = 1'b1;
        m_och   = prev;
        m_oeve  = ch_eve[prev];
        m_opol  = ch_pol[prev];
      end else begin
        m_valid = 1'b0;
      end
      m_frame = en && (m_cnt == 0);
      m_gray  = m_cnt ^ (m_cnt >> 1);
      if (en && m_pend[owner]) begin
        m_gnt = owner;
        served[owner] = 1'b1;
      end else begin
        m_gnt = -1;
      end
      for (int k = 0; k < N_CH; k++) begin
        if (ch_req[k]) begin
          if (m_pend[k] && !served[k]) m_ovr[k] = 1'b1;
          m_pend[k] = 1'b1;
        end else if (served[k]) begin
          m_pend[k] = 1'b0;
        end
      end
      if (en) m_cnt = (m_cnt + 1) % FRAME;
    end
  endtask

  // One clock: drive inputs at negedge, update model at posedge, compare 1 time unit later
  task automatic step(input bit rst, input bit e, input logic [7:0] req);
    logic [7:0] exp_gb;
    @(negedge clk_master);
    reset  = rst;
    en     = e;
    ch_req = req;
    ch_eve = 8'($urandom);
    ch_pol = 8'($urandom);
    @(posedge clk_master);
    model_edge();
    #1;
    exp_gb = (m_gnt >= 0) ? ~(8'd1 << m_gnt) : 8'hFF;
    check("grant_b",     grant_b,     exp_gb);
    check("out_valid",   out_valid,   m_valid);
    check("out_ch",      out_ch,      m_och);
    check("out_eve",     out_eve,     m_oeve);
    check("out_pol",     out_pol,     m_opol);
    check("frame_start", frame_start, m_frame);
    check("gray_out",    gray_out,    m_gray);
    check("overrun",     overrun,     m_ovr);
    if (grant_b !== 8'hFF) begin
      for (int k = 0; k < N_CH; k++) begin
        if (grant_b[k] === 1'b0) begin
          glog_step.push_back(step_no);
          glog_ch.push_back(k);
        end
      end
    end
    step_no++;
  endtask

  initial begin
    int exp_slot[8];
    int exp_ch[8];
    logic [CNT_W-1:0] prev_gray;
    int n3;
    int guard;
    int held;
    int ng;
    exp_slot = '{0, 1, 2, 4, 8, 16, 32, 64};
    exp_ch   = '{7, 0, 1, 2, 3, 4, 5, 6};

    // Reset state
    step(1, 0, 8'h00);
    step(1, 0, 8'h00);
    check("rst_grant_b",   grant_b,   8'hFF);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_gray",      gray_out,  7'h00);
    check("rst_overrun",   overrun,   8'h00);

    // Slot order and gray/wrap over 130 enabled cycles
    step(0, 0, 8'hFF);
    glog_step.delete();
    glog_ch.delete();
    step_no   = 0;
    prev_gray = gray_out;
    for (int i = 0; i < 130; i++) begin
      step(0, 1, 8'h00);
      if (i > 0) check("gray_one_bit", $countones(gray_out ^ prev_gray), 1);
      if (i == 127) check("gray_before_wrap", gray_out, 7'h40);
      if (i == 128) check("gray_after_wrap",  gray_out, 7'h00);
      if (i == 0 || i == 128) check("frame_start_slot0", frame_start, 1'b1);
      prev_gray = gray_out;
    end
    check("slot_grant_count", glog_step.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < glog_step.size()) begin
        check("slot_order_step", glog_step[i], exp_slot[i]);
        check("slot_order_ch",   glog_ch[i],   exp_ch[i]);
      end
    end

    // Overrun: two requests for core 3 before its slot at cnt=8
    guard = 0;
    while (m_cnt != 3 && guard < 200) begin
      step(0, 1, 8'h00);
      guard++;
    end
    check("ovr_reached_cnt3", m_cnt, 3);
    step(0, 1, 8'h08);
    step(0, 1, 8'h00);
    step(0, 1, 8'h08);
    n3 = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 8'h00);
      if (out_valid === 1'b1 && out_ch === 3'd3) n3++;
    end
    check("ovr_flag",      overrun[3], 1'b1);
    check("ovr_one_valid", n3, 1);

    // Freeze with all cores pending and a grant in flight
    step(0, 1, 8'hFF);
    guard = 0;
    while (grant_b === 8'hFF && guard < 10) begin
      step(0, 1, 8'h00);
      guard++;
    end
    check("freeze_grant_seen", grant_b !== 8'hFF, 1'b1);
    held = m_cnt;
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 8'h00);
      check("freeze_grant_b", grant_b, 8'hFF);
      if (i >= 2) check("freeze_out_valid", out_valid, 1'b0);
      check("freeze_gray", gray_out, held ^ (held >> 1));
    end
    for (int i = 0; i < 5; i++) step(0, 1, 8'h00);
    check("ovr_sticky", overrun[3], 1'b1);

    // Reset for 3 cycles mid-run with grants active
    step(0, 1, 8'hFF);
    step(0, 1, 8'h00);
    for (int i = 0; i < 3; i++) step(1, 1, 8'h00);
    check("mid_rst_grant_b",   grant_b,   8'hFF);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_gray",      gray_out,  7'h00);
    check("mid_rst_overrun",   overrun,   8'h00);
    ng = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 8'h00);
      if (grant_b !== 8'hFF) ng++;
    end
    check("post_rst_no_grant", ng, 0);

    // Request on the same edge core 0 is granted
    step(1, 0, 8'h00);
    step(0, 1, 8'h01);
    step(0, 1, 8'h01);
    check("simul_grant_cnt1", grant_b, 8'hFE);
    step(0, 1, 8'h00);
    check("simul_idle_cnt2",  grant_b, 8'hFF);
    step(0, 1, 8'h00);
    check("simul_grant_cnt3", grant_b, 8'hFE);
    check("simul_overrun0",   overrun[0], 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 700; i++) begin
      step(($urandom % 200) == 0, ($urandom % 8) != 0,
           8'($urandom & $urandom & $urandom & $urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
